// File: rtl/sorter_pkg.sv
// Constants and types shared by the Sorter and its downstream drain logic.
package sorter_pkg;

  localparam int unsigned SIZE  = 16;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned IDXW  = $clog2(SIZE);

  typedef enum logic {
    IDLE,
    DRAIN
  } drain_state_t;

  typedef logic [WIDTH-1:0] elem_t;

endpackage

// File: rtl/sort_order_check.sv
// Checks that the elements of one vector arrive in non-decreasing order;
// the error flag is sticky until reset.
module sort_order_check
  import sorter_pkg::*;
#(
  parameter int unsigned WIDTH = sorter_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fire,
  input  logic             first,
  input  logic [WIDTH-1:0] data,
  output logic             err
);

  logic [WIDTH-1:0] prev;

  // The first element of a vector is never compared with the previous vector's tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      err  <= 1'b0;
    end else if (fire) begin
      prev <= data;
      if (!first && (data < prev)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sorted_vector_drain.sv
// Captures one sorted vector from the Sorter and streams it out element by
// element over valid/ready, counting completed vectors.
module sorted_vector_drain
  import sorter_pkg::*;
#(
  parameter int unsigned SIZE  = sorter_pkg::SIZE,
  parameter int unsigned WIDTH = sorter_pkg::WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [SIZE*WIDTH-1:0]     in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(SIZE)-1:0]   out_index,
  output logic                      out_last,
  output logic                      order_err,
  output logic [15:0]               vec_count
);

  localparam int unsigned IDXW = $clog2(SIZE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SIZE - 1);

  drain_state_t          state, state_d;
  logic [SIZE*WIDTH-1:0] vec, vec_d;
  logic [IDXW-1:0]       idx, idx_d;
  logic [15:0]           cnt, cnt_d;
  logic                  fire, capture, at_last;

  assign out_valid = (state == DRAIN);
  assign at_last   = (idx == LAST_IDX);
  assign out_last  = at_last && out_valid;
  assign fire      = out_valid && out_ready;
  assign in_ready  = !rst && ((state == IDLE) || (out_last && out_ready));
  assign capture   = in_valid && in_ready;
  assign out_data  = out_valid ? vec[idx*WIDTH +: WIDTH] : '0;
  assign out_index = idx;
  assign vec_count = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec   <= '0;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      vec   <= vec_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
    end
  end

  // A capture on the final beat overrides the return to IDLE, giving back-to-back vectors.
  always_comb begin
    state_d = state;
    vec_d   = vec;
    idx_d   = idx;
    cnt_d   = cnt;
    if (fire) begin
      if (!at_last) begin
        idx_d = idx + 1'b1;
      end else begin
        idx_d   = '0;
        cnt_d   = cnt + 16'd1;
        state_d = IDLE;
      end
    end
    if (capture) begin
      vec_d   = in_data;
      idx_d   = '0;
      state_d = DRAIN;
    end
  end

  sort_order_check #(
    .WIDTH(WIDTH)
  ) u_order_check (
    .clk  (clk),
    .rst  (rst),
    .fire (fire),
    .first(idx == '0),
    .data (out_data),
    .err  (order_err)
  );

endmodule

// File: tb/tb_sorted_vector_drain.sv
// Directed, table-driven bench for sorted_vector_drain with hand-written
// sequences for reset, back-to-back capture and abort mid-drain.
module tb_sorted_vector_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [3:0]  out_index;
  logic        out_last;
  logic        order_err;
  logic [15:0] vec_count;

  int          checks = 0;
  int          errors = 0;
  logic        m_err;
  logic [15:0] m_cnt;

  typedef struct {
    logic [63:0] data;
    bit          stall;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_rec_t;

  vec_rec_t tbl[5];

  always #5 clk = ~clk;

  sorted_vector_drain #(
    .SIZE (16),
    .WIDTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last),
    .order_err(order_err),
    .vec_count(vec_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] el(input logic [63:0] v, input int i);
    return v[i*4 +: 4];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [63:0] v);
    in_data   = v;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    tick;
    in_valid = 1'b0;
    in_data  = ~v;
  endtask

  task automatic drain(input logic [63:0] v, input bit stall, input bit hold_next,
                       input logic [63:0] nxt);
    int k;
    int c;
    k = 0;
    c = 0;
    if (hold_next) begin
      in_valid = 1'b1;
      in_data  = nxt;
    end
    while (k < 16 && c < 200) begin
      out_ready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      #1;
      chk("beat_valid", out_valid, 1);
      chk("beat_index", out_index, k);
      chk("beat_data", out_data, el(v, k));
      chk("beat_last", out_last, (k == 15));
      chk("beat_in_ready", in_ready, (k == 15) && out_ready);
      chk("beat_order_err", order_err, m_err);
      if (out_ready) begin
        if (k > 0 && el(v, k) < el(v, k - 1)) m_err = 1'b1;
        if (k == 15) m_cnt++;
        k++;
      end
      c++;
      tick;
    end
    if (k < 16) chk("drain_timeout", k, 16);
    if (hold_next) in_valid = 1'b0;
    chk("after_order_err", order_err, m_err);
    chk("after_vec_count", vec_count, m_cnt);
    chk("after_out_valid", out_valid, hold_next);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{64'hEDCBA98765432110, 1'b0, 1'b0, 16'd1};
    tbl[1] = '{64'hFFEDCBA987654321, 1'b1, 1'b0, 16'd2};
    tbl[2] = '{64'h8888777766665555, 1'b0, 1'b0, 16'd3};
    tbl[3] = '{64'hFEDCBA9873943210, 1'b0, 1'b1, 16'd4};
    tbl[4] = '{64'hFFFFEEEE11110000, 1'b1, 1'b1, 16'd5};

    // Reset held with in_valid asserted
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h0123456789ABCDEF;
    out_ready = 1'b1;
    m_err     = 1'b0;
    m_cnt     = '0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
    end
    chk("rst_order_err", order_err, 0);
    chk("rst_vec_count", vec_count, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    tick;
    chk("rel_out_valid", out_valid, 0);

    for (int i = 0; i < 5; i++) begin
      capture(tbl[i].data);
      drain(tbl[i].data, tbl[i].stall, 1'b0, 64'd0);
      chk("tbl_vec_count", vec_count, tbl[i].exp_cnt);
      chk("tbl_order_err", order_err, tbl[i].exp_err);
    end

    // Back-to-back: B captured on A's last beat, no idle cycle between them
    capture(64'hFFEEDDCCBBAA9988);
    drain(64'hFFEEDDCCBBAA9988, 1'b0, 1'b1, 64'h7654321000000000);
    chk("b2b_index0", out_index, 0);
    drain(64'h7654321000000000, 1'b0, 1'b0, 64'd0);
    chk("b2b_vec_count", vec_count, 16'd7);

    // Reset at beat 7 aborts the drain and clears sticky state
    capture(64'hFEDCBA9876543210);
    for (int k = 0; k < 7; k++) begin
      out_ready = 1'b1;
      #1;
      chk("mid_index", out_index, k);
      tick;
    end
    #1;
    chk("mid_beat7", out_index, 7);
    chk("mid_err_before", order_err, 1);
    rst = 1'b1;
    tick;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_vec_count", vec_count, 0);
    chk("mid_order_err", order_err, 0);
    rst   = 1'b0;
    m_err = 1'b0;
    m_cnt = '0;
    capture(64'h3333222211110000);
    drain(64'h3333222211110000, 1'b0, 1'b0, 64'd0);
    chk("post_vec_count", vec_count, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
